// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory controller channel among icache, dcache and IO.
// IO has priority, bounded by a starvation counter; the two caches alternate round-robin.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  is_io_buffer_full,
  input  logic                  icache_valid,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_ready,
  output logic [LINE_WIDTH-1:0] icache_data,
  input  logic                  dcache_valid,
  input  logic                  dcache_rw,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic                  dcache_ready,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  input  logic                  io_valid,
  input  logic                  io_rw,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [7:0]            io_wdata,
  output logic                  io_ready,
  output logic [7:0]            io_rdata,
  output logic                  mem_valid,
  output logic [1:0]            mem_src,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] SRC_IC = 2'd0;
  localparam logic [1:0] SRC_DC = 2'd1;
  localparam logic [1:0] SRC_IO = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_rr_ptr;
  logic [3:0] r_starve_cnt;

  logic w_io_elig;
  logic w_cache_any;
  logic w_grant_io;
  logic w_grant_dc;
  logic w_grant_ic;

  // A full UART buffer only blocks IO writes; IO reads stay eligible.
  assign w_io_elig   = io_valid & ~(io_rw & is_io_buffer_full);
  assign w_cache_any = icache_valid | dcache_valid;
  assign w_grant_io  = w_io_elig & (~w_cache_any | (r_starve_cnt < LIMIT));
  assign w_grant_dc  = ~w_grant_io & dcache_valid & (~icache_valid | r_rr_ptr);
  assign w_grant_ic  = ~w_grant_io & icache_valid & (~dcache_valid | ~r_rr_ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 1'b0;
      r_starve_cnt <= 4'd0;
      mem_valid    <= 1'b0;
      mem_src      <= 2'd0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      icache_ready <= 1'b0;
      icache_data  <= '0;
      dcache_ready <= 1'b0;
      dcache_rdata <= '0;
      io_ready     <= 1'b0;
      io_rdata     <= '0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_io) begin
            mem_valid <= 1'b1;
            mem_src   <= SRC_IO;
            mem_rw    <= io_rw;
            mem_addr  <= io_addr;
            mem_wdata <= {{(LINE_WIDTH-8){1'b0}}, io_wdata};
            r_state   <= S_BUSY;
            if (!w_cache_any)
              r_starve_cnt <= 4'd0;
            else if (r_starve_cnt != 4'hF)
              r_starve_cnt <= r_starve_cnt + 4'd1;
          end else if (w_grant_dc) begin
            mem_valid    <= 1'b1;
            mem_src      <= SRC_DC;
            mem_rw       <= dcache_rw;
            mem_addr     <= dcache_addr;
            mem_wdata    <= dcache_wdata;
            r_state      <= S_BUSY;
            r_rr_ptr     <= 1'b0;
            r_starve_cnt <= 4'd0;
          end else if (w_grant_ic) begin
            mem_valid    <= 1'b1;
            mem_src      <= SRC_IC;
            mem_rw       <= 1'b0;
            mem_addr     <= icache_addr;
            mem_wdata    <= '0;
            r_state      <= S_BUSY;
            r_rr_ptr     <= 1'b1;
            r_starve_cnt <= 4'd0;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            r_state   <= S_RESP;
            case (mem_src)
              SRC_IC: begin
                icache_ready <= 1'b1;
                icache_data  <= mem_rdata;
              end
              SRC_DC: begin
                dcache_ready <= 1'b1;
                if (!mem_rw) dcache_rdata <= mem_rdata;
              end
              SRC_IO: begin
                io_ready <= 1'b1;
                if (!mem_rw) io_rdata <= mem_rdata[7:0];
              end
              default: ;
            endcase
          end
        end
        S_RESP: begin
          icache_ready <= 1'b0;
          dcache_ready <= 1'b0;
          io_ready     <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// request traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int AW    = 32;
  localparam int LW    = 128;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, is_io_buffer_full;
  logic          icache_valid;
  logic [AW-1:0] icache_addr;
  logic          icache_ready;
  logic [LW-1:0] icache_data;
  logic          dcache_valid, dcache_rw;
  logic [AW-1:0] dcache_addr;
  logic [LW-1:0] dcache_wdata;
  logic          dcache_ready;
  logic [LW-1:0] dcache_rdata;
  logic          io_valid, io_rw;
  logic [AW-1:0] io_addr;
  logic [7:0]    io_wdata;
  logic          io_ready;
  logic [7:0]    io_rdata;
  logic          mem_valid;
  logic [1:0]    mem_src;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .is_io_buffer_full(is_io_buffer_full),
    .icache_valid(icache_valid), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_data(icache_data),
    .dcache_valid(dcache_valid), .dcache_rw(dcache_rw), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_ready(dcache_ready), .dcache_rdata(dcache_rdata),
    .io_valid(io_valid), .io_rw(io_rw), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ready(io_ready), .io_rdata(io_rdata),
    .mem_valid(mem_valid), .mem_src(mem_src), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: arbitration history and last data returned per requester.
  int            m_turn;
  int            m_starve;
  logic [LW-1:0] m_ic_data, m_dc_data;
  logic [7:0]    m_io_data;
  int            last_src;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick();
    bit io_ok  = io_valid && !(io_rw && is_io_buffer_full);
    bit caches = icache_valid || dcache_valid;
    if (io_ok && (!caches || m_starve < LIMIT)) return 2;
    if (icache_valid && dcache_valid) return m_turn;
    if (icache_valid) return 0;
    if (dcache_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_turn    = 0;
    m_starve  = 0;
    m_ic_data = '0;
    m_dc_data = '0;
    m_io_data = '0;
  endtask

  task automatic clear_inputs();
    is_io_buffer_full = 0;
    icache_valid = 0; icache_addr = '0;
    dcache_valid = 0; dcache_rw = 0; dcache_addr = '0; dcache_wdata = '0;
    io_valid = 0; io_rw = 0; io_addr = '0; io_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  // Pulse reset between clock edges and return the model to its reset state.
  task automatic pulse_reset();
    rst = 1'b1;
    clear_inputs();
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  // One full transaction starting in IDLE: grant, hold, completion, ready pulse.
  task automatic run_txn(input int lat, input int stall, input logic [LW-1:0] rdata);
    int            w;
    bit            caches;
    logic [AW-1:0] ea;
    logic          ew;
    logic [LW-1:0] ewd;
    logic [2:0]    erdy;
    w      = pick();
    caches = icache_valid || dcache_valid;
    ea = '0; ew = 1'b0; ewd = '0;
    case (w)
      0: begin ea = icache_addr; ew = 1'b0; end
      1: begin ea = dcache_addr; ew = dcache_rw; ewd = dcache_wdata; end
      2: begin ea = io_addr; ew = io_rw; ewd = {{(LW-8){1'b0}}, io_wdata}; end
      default: ;
    endcase
    tick();
    last_src = w;
    if (w < 0) begin
      check("idle_no_grant", mem_valid, 0);
      return;
    end
    check("grant_valid", mem_valid, 1);
    check("grant_src", mem_src, w);
    check("grant_addr", mem_addr, ea);
    check("grant_rw", mem_rw, ew);
    if (w != 0) check("grant_wdata", mem_wdata, ewd);
    if (w == 2) m_starve = caches ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
    else begin
      m_turn   = 1 - w;
      m_starve = 0;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      check("busy_valid", mem_valid, 1);
      check("busy_addr", mem_addr, ea);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    if (stall > 0) begin
      rdy = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        check("stall_valid", mem_valid, 1);
        check("stall_ready", {icache_ready, dcache_ready, io_ready}, 0);
      end
      rdy = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
    if (!ew) begin
      case (w)
        0: m_ic_data = rdata;
        1: m_dc_data = rdata;
        default: m_io_data = rdata[7:0];
      endcase
    end
    erdy = (w == 0) ? 3'b100 : (w == 1) ? 3'b010 : 3'b001;
    check("done_ready", {icache_ready, dcache_ready, io_ready}, erdy);
    check("done_mem_valid", mem_valid, 0);
    check("ic_data", icache_data, m_ic_data);
    check("dc_data", dcache_rdata, m_dc_data);
    check("io_data", io_rdata, m_io_data);
    case (w)
      0: icache_valid = 1'b0;
      1: dcache_valid = 1'b0;
      default: io_valid = 1'b0;
    endcase
    tick();
    check("ready_one_cycle", {icache_ready, dcache_ready, io_ready}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] seq;
    rst = 1'b1;
    rdy = 1'b1;
    clear_inputs();
    model_reset();
    last_src = -1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_bus", {mem_src, mem_rw, mem_addr}, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_readys", {icache_ready, dcache_ready, io_ready}, 0);
    check("rst_data", icache_data | dcache_rdata | {{(LW-8){1'b0}}, io_rdata}, 0);

    // Single icache read, 17-cycle controller latency.
    icache_valid = 1'b1;
    icache_addr  = 32'h1000;
    run_txn(17, 0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("ic_first_src", last_src, 0);
    check("ic_line", icache_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // Both caches from reset alternate.
    pulse_reset();
    tick();
    icache_valid = 1'b1; icache_addr = $urandom;
    dcache_valid = 1'b1; dcache_addr = $urandom; dcache_wdata = rand_line();
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      run_txn(2, 0, rand_line());
      seq = {seq[9:0], 2'(last_src)};
      if (last_src == 0) begin icache_valid = 1'b1; icache_addr = $urandom; end
      else begin dcache_valid = 1'b1; dcache_addr = $urandom; end
    end
    check("rr_order", seq[7:0], 8'b00_01_00_01);
    clear_inputs();

    // IO reads held against a pending dcache read: starvation bound.
    io_valid = 1'b1; io_rw = 1'b0; io_addr = $urandom;
    dcache_valid = 1'b1; dcache_rw = 1'b0; dcache_addr = $urandom;
    seq = '0;
    for (int k = 0; k < 6; k++) begin
      run_txn(1, 0, rand_line());
      seq = {seq[9:0], 2'(last_src)};
      io_valid = 1'b1; io_addr = $urandom;
      dcache_valid = 1'b1;
    end
    check("starve_order", seq, {2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2});
    clear_inputs();

    // IO write blocked by a full buffer, then released.
    io_valid = 1'b1; io_rw = 1'b1; io_addr = 32'h40; io_wdata = 8'hAB;
    is_io_buffer_full = 1'b1;
    icache_valid = 1'b1; icache_addr = 32'h2000;
    run_txn(3, 0, rand_line());
    check("full_skips_io", last_src, 0);
    run_txn(0, 0, rand_line());
    check("full_blocks_io", last_src, -1);
    is_io_buffer_full = 1'b0;
    run_txn(2, 0, rand_line());
    check("io_write_src", last_src, 2);
    clear_inputs();

    // rdy low for three cycles with mem_ready pending.
    icache_valid = 1'b1; icache_addr = $urandom;
    run_txn(2, 3, rand_line());

    // Reset mid-transaction: request abandoned, pointer back to icache.
    icache_valid = 1'b1; icache_addr = $urandom;
    run_txn(1, 0, rand_line());
    io_valid = 1'b1; io_rw = 1'b0; io_addr = $urandom;
    tick();
    check("pre_rst_grant", {mem_valid, mem_src}, {1'b1, 2'd2});
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_drop", mem_valid, 0);
    clear_inputs();
    #1;
    rst = 1'b0;
    model_reset();
    mem_ready = 1'b1;
    tick();
    check("rst_no_ready", {icache_ready, dcache_ready, io_ready, mem_valid}, 0);
    mem_ready = 1'b0;
    icache_valid = 1'b1; icache_addr = $urandom;
    dcache_valid = 1'b1; dcache_addr = $urandom;
    run_txn(1, 0, rand_line());
    check("post_rst_src", last_src, 0);
    clear_inputs();

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      if (!icache_valid && $urandom_range(1, 0) == 1) begin
        icache_valid = 1'b1; icache_addr = $urandom;
      end
      if (!dcache_valid && $urandom_range(1, 0) == 1) begin
        dcache_valid = 1'b1; dcache_rw = 1'($urandom_range(1, 0));
        dcache_addr = $urandom; dcache_wdata = rand_line();
      end
      if (!io_valid && $urandom_range(1, 0) == 1) begin
        io_valid = 1'b1; io_rw = 1'($urandom_range(1, 0));
        io_addr = $urandom; io_wdata = 8'($urandom_range(255, 0));
      end
      is_io_buffer_full = ($urandom_range(3, 0) == 0);
      if ($urandom_range(7, 0) == 0) begin
        rdy = 1'b0;
        tick();
        tick();
        check("idle_freeze", mem_valid, 0);
        rdy = 1'b1;
      end
      run_txn($urandom_range(6, 0),
              ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0,
              rand_line());
      if (last_src < 0) is_io_buffer_full = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
